// File: rtl/tx_serial_fifo_if.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tx_serial_fifo_if : write-side and serial-side signal bundle for the     |
// |                     I2S transmit FIFO.                                   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface tx_serial_fifo_if #(
    parameter int WIDTH = 32,
    parameter int ADDR  = 3
);
    logic             wr_en;
    logic [WIDTH-1:0] din;
    logic             full;
    logic             almost_full;
    logic [ADDR:0]    wlevel;
    logic             rd_en;
    logic [1:0]       frame_size;
    logic             mute;
    logic             underrun_clr;
    logic             dout;
    logic             word_start;
    logic             empty;
    logic             underrun;

    modport master (
        output wr_en, din, rd_en, frame_size, mute, underrun_clr,
        input  full, almost_full, wlevel, dout, word_start, empty, underrun
    );

    modport slave (
        input  wr_en, din, rd_en, frame_size, mute, underrun_clr,
        output full, almost_full, wlevel, dout, word_start, empty, underrun
    );
endinterface
`default_nettype wire

// File: rtl/tx_serial_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tx_serial_fifo : async FIFO, parallel words in on wclk, MSB-first serial |
// | slots out on negedge rclk. Optional macro TXFIFO_LEVEL_EN adds wlevel.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tx_serial_fifo #(
    parameter int WIDTH    = 32,
    parameter int ADDR     = 3,
    parameter int AF_LEVEL = 6
) (
    input  logic            wclk,
    input  logic            rclk,
    input  logic            rst_,
    tx_serial_fifo_if.slave bus
);
    localparam int c_DEPTH = 1 << ADDR;
    localparam int c_CW    = $clog2(WIDTH);
    localparam logic [c_CW-1:0] c_NM1_16 = c_CW'(15);
    localparam logic [c_CW-1:0] c_NM1_24 = c_CW'((WIDTH >= 24) ? 23 : WIDTH - 1);
    localparam logic [c_CW-1:0] c_NM1_32 = c_CW'((WIDTH >= 32) ? 31 : WIDTH - 1);

    typedef enum logic [0:0] {
        S_START = 1'b0,
        S_SHIFT = 1'b1
    } rd_state_t;

    logic [WIDTH-1:0] r_mem [c_DEPTH];

    logic [ADDR:0] r_wbin, r_wgray, r_rgray_s1, r_rgray_s2;
    logic [ADDR:0] w_wbin_nxt, w_wgray_nxt;
    logic          w_wr_ok, r_full;

    logic [ADDR:0] r_rbin, r_rgray, r_wgray_s1, r_wgray_s2;
    logic [ADDR:0] w_rbin_nxt, w_rgray_nxt;

    rd_state_t       r_state, w_state_nxt;
    logic [c_CW-1:0] r_cnt, w_cnt_nxt, w_idx, w_nm1_new;
    logic            r_slot_valid, w_valid_nxt, w_valid_cur;
    logic            r_empty, r_dout, r_word_start, r_underrun;
    logic            w_dout_nxt, w_ws_nxt, w_rinc, w_ur_set;
    logic [WIDTH-1:0] w_rword;

    // ---------------- write domain ----------------
    assign w_wr_ok     = bus.wr_en && !r_full;
    assign w_wbin_nxt  = r_wbin + {{ADDR{1'b0}}, w_wr_ok};
    assign w_wgray_nxt = (w_wbin_nxt >> 1) ^ w_wbin_nxt;

    always_ff @(posedge wclk) begin
        if (w_wr_ok) begin
            r_mem[r_wbin[ADDR-1:0]] <= bus.din;
        end
    end

    always_ff @(posedge wclk or negedge rst_) begin
        if (!rst_) begin
            r_wbin     <= '0;
            r_wgray    <= '0;
            r_rgray_s1 <= '0;
            r_rgray_s2 <= '0;
            r_full     <= 1'b0;
        end else begin
            r_wbin     <= w_wbin_nxt;
            r_wgray    <= w_wgray_nxt;
            r_rgray_s1 <= r_rgray;
            r_rgray_s2 <= r_rgray_s1;
            // Same address, opposite lap: the two Gray MSBs differ.
            r_full     <= (w_wgray_nxt == {~r_rgray_s2[ADDR:ADDR-1], r_rgray_s2[ADDR-2:0]});
        end
    end

    assign bus.full = r_full;

`ifdef TXFIFO_LEVEL_EN
    localparam logic [ADDR:0] c_AF = (ADDR+1)'(AF_LEVEL);

    logic [ADDR:0] w_rbin_sync, w_level_nxt, r_wlevel;
    logic          r_almost_full;

    always_comb begin
        w_rbin_sync = '0;
        for (int i = 0; i <= ADDR; i++) begin
            w_rbin_sync[i] = ^(r_rgray_s2 >> i);
        end
    end

    assign w_level_nxt = w_wbin_nxt - w_rbin_sync;

    always_ff @(posedge wclk or negedge rst_) begin
        if (!rst_) begin
            r_wlevel      <= '0;
            r_almost_full <= 1'b0;
        end else begin
            r_wlevel      <= w_level_nxt;
            r_almost_full <= (w_level_nxt >= c_AF);
        end
    end

    assign bus.wlevel      = r_wlevel;
    assign bus.almost_full = r_almost_full;
`else
    assign bus.wlevel      = '0;
    assign bus.almost_full = 1'b0;
`endif

    // ---------------- read domain (negedge rclk) ----------------
    assign w_rword     = r_mem[r_rbin[ADDR-1:0]];
    assign w_rbin_nxt  = r_rbin + {{ADDR{1'b0}}, w_rinc};
    assign w_rgray_nxt = (w_rbin_nxt >> 1) ^ w_rbin_nxt;

    always_comb begin
        w_nm1_new = c_NM1_32;
        case (bus.frame_size)
            2'b00:   w_nm1_new = c_NM1_16;
            2'b01:   w_nm1_new = c_NM1_24;
            default: w_nm1_new = c_NM1_32;
        endcase
    end

    always_ff @(negedge rclk or negedge rst_) begin
        if (!rst_) begin
            r_state <= S_START;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_valid_nxt = r_slot_valid;
        w_dout_nxt  = r_dout;
        w_ws_nxt    = r_word_start;
        w_rinc      = 1'b0;
        w_ur_set    = 1'b0;
        w_idx       = r_cnt;
        w_valid_cur = r_slot_valid;
        // At a slot start the bit index and validity come from this edge's inputs.
        if (r_state == S_START) begin
            w_idx       = w_nm1_new;
            w_valid_cur = !r_empty;
        end
        if (bus.rd_en) begin
            w_valid_nxt = w_valid_cur;
            w_ws_nxt    = (r_state == S_START);
            w_ur_set    = (r_state == S_START) && r_empty;
            w_dout_nxt  = w_valid_cur && !bus.mute && w_rword[w_idx];
            if (w_idx == '0) begin
                w_state_nxt = S_START;
                w_rinc      = w_valid_cur;
            end else begin
                w_state_nxt = S_SHIFT;
                w_cnt_nxt   = w_idx - c_CW'(1);
            end
        end
    end

    always_ff @(negedge rclk or negedge rst_) begin
        if (!rst_) begin
            r_rbin       <= '0;
            r_rgray      <= '0;
            r_wgray_s1   <= '0;
            r_wgray_s2   <= '0;
            r_empty      <= 1'b1;
            r_cnt        <= '0;
            r_slot_valid <= 1'b0;
            r_dout       <= 1'b0;
            r_word_start <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_rbin       <= w_rbin_nxt;
            r_rgray      <= w_rgray_nxt;
            r_wgray_s1   <= r_wgray;
            r_wgray_s2   <= r_wgray_s1;
            r_empty      <= (w_rgray_nxt == r_wgray_s2);
            r_cnt        <= w_cnt_nxt;
            r_slot_valid <= w_valid_nxt;
            r_dout       <= w_dout_nxt;
            r_word_start <= w_ws_nxt;
            if (w_ur_set) begin
                r_underrun <= 1'b1;
            end else if (bus.underrun_clr) begin
                r_underrun <= 1'b0;
            end
        end
    end

    assign bus.dout       = r_dout;
    assign bus.word_start = r_word_start;
    assign bus.empty      = r_empty;
    assign bus.underrun   = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_tx_serial_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_tx_serial_fifo : random stimulus against a queue model of the FIFO    |
// | and a spec-level slot model (N bits, MSB first, zero void slots).        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_tx_serial_fifo;
    localparam int WIDTH    = 32;
    localparam int ADDR     = 3;
    localparam int AF_LEVEL = 6;

    logic wclk = 1'b0;
    logic rclk = 1'b0;
    logic rst_ = 1'b0;
    int   wh   = 5;
    int   rh   = 7;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] model_q [$];

    tx_serial_fifo_if #(.WIDTH(WIDTH), .ADDR(ADDR)) bus ();

    tx_serial_fifo #(.WIDTH(WIDTH), .ADDR(ADDR), .AF_LEVEL(AF_LEVEL)) dut (
        .wclk (wclk),
        .rclk (rclk),
        .rst_ (rst_),
        .bus  (bus)
    );

    initial forever #(wh) wclk = ~wclk;
    initial forever #(rh) rclk = ~rclk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    function automatic int fs_bits(input logic [1:0] fs);
        return (fs == 2'b00) ? 16 : (fs == 2'b01) ? 24 : 32;
    endfunction

    function automatic logic [31:0] slot_mask(input int n);
        logic [32:0] m;
        m = (33'd1 << n) - 33'd1;
        return m[31:0];
    endfunction

    task automatic write_word(input logic [31:0] d);
        @(negedge wclk);
        bus.wr_en = 1'b1;
        bus.din   = d;
        @(negedge wclk);
        bus.wr_en = 1'b0;
    endtask

    task automatic wait_not_empty(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge rclk);
            if (!bus.empty) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // One slot of n bits; outputs sampled on posedge rclk, away from the negedge shift.
    task automatic read_slot(input int n, input logic [1:0] fs, input bit mute_all,
                             input bit clr_first, input int switch_at,
                             output logic [31:0] v, output int ws_cnt, output logic ws_first);
        v = '0; ws_cnt = 0; ws_first = 1'b0;
        @(posedge rclk);
        bus.rd_en        = 1'b1;
        bus.frame_size   = fs;
        bus.mute         = mute_all;
        bus.underrun_clr = clr_first;
        for (int i = 0; i < n; i++) begin
            @(posedge rclk);
            v = {v[30:0], bus.dout};
            if (bus.word_start) ws_cnt++;
            if (i == 0) ws_first = bus.word_start;
            bus.underrun_clr = 1'b0;
            if (i == switch_at) bus.frame_size = 2'b01;
            if (i == n - 1) begin
                bus.rd_en = 1'b0;
                bus.mute  = 1'b0;
            end
        end
    endtask

    task automatic pulse_clr();
        @(posedge rclk);
        bus.underrun_clr = 1'b1;
        @(posedge rclk);
        bus.underrun_clr = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] v; int wc; logic wf; bit ok;
        read_slot(16, 2'b00, 0, 0, -1, v, wc, wf);
        write_word(32'h1234_5678);
        write_word(32'h9ABC_DEF0);
        wait_not_empty(ok);
        @(posedge rclk); bus.rd_en = 1'b1;
        repeat (5) @(posedge rclk);
        #2 rst_ = 1'b0;
        bus.rd_en = 1'b0;
        #1;
        n_checks++; if (bus.full !== 1'b0) $display("FAIL reset_full: got %b want 0", bus.full); else n_pass++;
        n_checks++; if (bus.almost_full !== 1'b0) $display("FAIL reset_af: got %b want 0", bus.almost_full); else n_pass++;
        n_checks++; if (bus.wlevel !== '0) $display("FAIL reset_wlevel: got %0d want 0", bus.wlevel); else n_pass++;
        n_checks++; if (bus.empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", bus.empty); else n_pass++;
        n_checks++; if (bus.dout !== 1'b0) $display("FAIL reset_dout: got %b want 0", bus.dout); else n_pass++;
        n_checks++; if (bus.word_start !== 1'b0) $display("FAIL reset_ws: got %b want 0", bus.word_start); else n_pass++;
        n_checks++; if (bus.underrun !== 1'b0) $display("FAIL reset_underrun: got %b want 0", bus.underrun); else n_pass++;
        repeat (3) @(posedge wclk);
        @(negedge wclk); rst_ = 1'b1;
        repeat (8) @(posedge rclk);
        n_checks++; if (bus.empty !== 1'b1) $display("FAIL reset_no_stale: empty got %b want 1", bus.empty); else n_pass++;
        write_word(32'h0000_A5F0);
        wait_not_empty(ok);
        n_checks++; if (ok !== 1'b1) $display("FAIL reset_wait: empty never fell, got %b want 1", ok); else n_pass++;
        read_slot(16, 2'b00, 0, 0, -1, v, wc, wf);
        n_checks++; if (v[15:0] !== 16'hA5F0) $display("FAIL reset_word: got %h want a5f0", v[15:0]); else n_pass++;
        n_checks++; if (wf !== 1'b1 || wc != 1) $display("FAIL reset_ws_first: got first=%b count=%0d want 1/1", wf, wc); else n_pass++;
        repeat (2) @(posedge rclk);
        n_checks++; if (bus.empty !== 1'b1) $display("FAIL reset_empty_after: got %b want 1", bus.empty); else n_pass++;
        n_checks++; if (bus.underrun !== 1'b0) $display("FAIL reset_no_void: underrun got %b want 0", bus.underrun); else n_pass++;
    endtask

    task automatic test_full();
        logic [31:0] v, d, e; int wc; logic wf; bit ok;
        for (int k = 0; k < 9; k++) begin
            d = $urandom;
            write_word(d);
            if (k < 8) begin
                model_q.push_back(d);
                n_checks++; if (bus.full !== (k == 7)) $display("FAIL full_write%0d: got %b want %b", k, bus.full, (k == 7)); else n_pass++;
`ifdef TXFIFO_LEVEL_EN
                n_checks++; if (bus.wlevel !== 4'(k + 1)) $display("FAIL wlevel_write%0d: got %0d want %0d", k, bus.wlevel, k + 1); else n_pass++;
                n_checks++; if (bus.almost_full !== (k + 1 >= AF_LEVEL)) $display("FAIL af_write%0d: got %b want %b", k, bus.almost_full, (k + 1 >= AF_LEVEL)); else n_pass++;
`else
                n_checks++; if (bus.wlevel !== '0 || bus.almost_full !== 1'b0) $display("FAIL level_off%0d: got %0d/%b want 0/0", k, bus.wlevel, bus.almost_full); else n_pass++;
`endif
            end else begin
                n_checks++; if (bus.full !== 1'b1) $display("FAIL full_ninth: got %b want 1", bus.full); else n_pass++;
`ifdef TXFIFO_LEVEL_EN
                n_checks++; if (bus.wlevel !== 4'd8) $display("FAIL wlevel_ninth: got %0d want 8", bus.wlevel); else n_pass++;
`endif
            end
        end
        for (int k = 0; k < 8; k++) begin
            wait_not_empty(ok);
            e = model_q.pop_front();
            read_slot(32, 2'b10, 0, 0, -1, v, wc, wf);
            n_checks++; if (v !== e) $display("FAIL full_read%0d: got %h want %h", k, v, e); else n_pass++;
        end
        repeat (10) @(posedge rclk);
        n_checks++; if (bus.empty !== 1'b1) $display("FAIL full_ninth_dropped: empty got %b want 1", bus.empty); else n_pass++;
        n_checks++; if (bus.full !== 1'b0) $display("FAIL full_cleared: got %b want 0", bus.full); else n_pass++;
    endtask

    task automatic test_underrun();
        logic [31:0] v; int wc; logic wf; bit ok;
        read_slot(16, 2'b00, 0, 0, -1, v, wc, wf);
        n_checks++; if (v[15:0] !== 16'h0000) $display("FAIL void_bits: got %h want 0000", v[15:0]); else n_pass++;
        n_checks++; if (bus.underrun !== 1'b1) $display("FAIL void_underrun: got %b want 1", bus.underrun); else n_pass++;
        n_checks++; if (wf !== 1'b1) $display("FAIL void_ws: got %b want 1", wf); else n_pass++;
        write_word(32'h0000_8001);
        wait_not_empty(ok);
        read_slot(16, 2'b00, 0, 0, -1, v, wc, wf);
        n_checks++; if (v[15:0] !== 16'h8001) $display("FAIL after_void_word: got %h want 8001", v[15:0]); else n_pass++;
        n_checks++; if (bus.underrun !== 1'b1) $display("FAIL underrun_sticky: got %b want 1", bus.underrun); else n_pass++;
        pulse_clr();
        @(posedge rclk);
        n_checks++; if (bus.underrun !== 1'b0) $display("FAIL underrun_clr: got %b want 0", bus.underrun); else n_pass++;
        read_slot(16, 2'b00, 0, 1, -1, v, wc, wf);
        n_checks++; if (bus.underrun !== 1'b1) $display("FAIL set_wins: got %b want 1", bus.underrun); else n_pass++;
        pulse_clr();
        @(posedge rclk);
    endtask

    task automatic test_frame_switch();
        logic [31:0] v; int wc; logic wf; bit ok;
        write_word(32'h00FF_FF01);
        write_word(32'h00C3_3C5A);
        wait_not_empty(ok);
        read_slot(16, 2'b00, 0, 0, 7, v, wc, wf);
        n_checks++; if (v[15:0] !== 16'hFF01) $display("FAIL fs_first: got %h want ff01", v[15:0]); else n_pass++;
        wait_not_empty(ok);
        read_slot(24, 2'b01, 0, 0, -1, v, wc, wf);
        n_checks++; if (v[23:0] !== 24'hC33C5A) $display("FAIL fs_second: got %h want c33c5a", v[23:0]); else n_pass++;
        n_checks++; if (wf !== 1'b1 || wc != 1) $display("FAIL fs_ws: got first=%b count=%0d want 1/1", wf, wc); else n_pass++;
        repeat (2) @(posedge rclk);
        n_checks++; if (bus.empty !== 1'b1) $display("FAIL fs_empty: got %b want 1", bus.empty); else n_pass++;
    endtask

    task automatic test_mute();
        logic [31:0] v, d0, d1; int wc; logic wf; bit ok;
        d0 = $urandom | 32'h1;
        d1 = $urandom;
        write_word(d0);
        write_word(d1);
        wait_not_empty(ok);
        read_slot(32, 2'b10, 1, 0, -1, v, wc, wf);
        n_checks++; if (v !== 32'h0) $display("FAIL mute_zero: got %h want 00000000", v); else n_pass++;
        wait_not_empty(ok);
        read_slot(32, 2'b10, 0, 0, -1, v, wc, wf);
        n_checks++; if (v !== d1) $display("FAIL mute_next: got %h want %h", v, d1); else n_pass++;
        repeat (2) @(posedge rclk);
        n_checks++; if (bus.empty !== 1'b1) $display("FAIL mute_empty: got %b want 1", bus.empty); else n_pass++;
    endtask

    task automatic test_stream(input int w_half, input int r_half);
        wh = w_half;
        rh = r_half;
        pulse_clr();
        fork
            begin
                int nw = 0;
                int guard = 0;
                while (nw < 40 && guard < 5000) begin
                    @(negedge wclk);
                    guard++;
                    if (!bus.full && $urandom_range(0, 1) == 1) begin
                        bus.wr_en = 1'b1;
                        bus.din   = $urandom;
                        model_q.push_back(bus.din);
                        nw++;
                    end else begin
                        bus.wr_en = 1'b0;
                    end
                end
                @(negedge wclk);
                bus.wr_en = 1'b0;
            end
            begin
                logic [31:0] v, e; int wc; logic wf; bit ok; logic [1:0] fs; int n;
                for (int k = 0; k < 40; k++) begin
                    wait_not_empty(ok);
                    n_checks++; if (ok !== 1'b1) $display("FAIL stream_wait%0d: empty never fell, got %b want 1", k, ok); else n_pass++;
                    if (!ok) break;
                    fs = 2'($urandom_range(0, 3));
                    n  = fs_bits(fs);
                    e  = (model_q.size() > 0) ? model_q.pop_front() : 32'hDEAD_BEEF;
                    read_slot(n, fs, 0, 0, -1, v, wc, wf);
                    n_checks++; if ((v & slot_mask(n)) !== (e & slot_mask(n)) || wf !== 1'b1)
                        $display("FAIL stream_word%0d: got %h ws=%b want %h ws=1 (n=%0d)", k, v & slot_mask(n), wf, e & slot_mask(n), n);
                    else n_pass++;
                end
            end
        join
        repeat (4) @(posedge rclk);
        n_checks++; if (bus.underrun !== 1'b0) $display("FAIL stream_no_void: underrun got %b want 0", bus.underrun); else n_pass++;
        n_checks++; if (bus.empty !== 1'b1) $display("FAIL stream_empty: got %b want 1", bus.empty); else n_pass++;
    endtask

    initial begin
        bus.wr_en        = 1'b0;
        bus.din          = '0;
        bus.rd_en        = 1'b0;
        bus.frame_size   = 2'b00;
        bus.mute         = 1'b0;
        bus.underrun_clr = 1'b0;
        repeat (3) @(posedge wclk);
        @(negedge wclk); rst_ = 1'b1;
        repeat (4) @(posedge rclk);
        test_reset();
        test_full();
        test_underrun();
        test_frame_switch();
        test_mute();
        test_stream(5, 20);
        test_stream(15, 5);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
